inv_mixcol_seq: RTL and testbench
=================================

Name: inv_mixcol_seq

Overview:
- Column-serial AES InvMixColumns stage of the decryption datapath.
- Sits directly upstream of the inverse ShiftRows stage and consumes the AddRoundKey result.
- Accepts one 128-bit state via valid/ready and transforms COLS_PER_CYCLE 32-bit columns per clock.
- Presents the full 128-bit result, held stable until the downstream stage takes it.

Parameters:
- COLS_PER_CYCLE, default 1: columns processed per clock; legal values 1, 2, 4; compute phase lasts 4/COLS_PER_CYCLE cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_state/in_bypass valid
- in_ready  output  1  block can accept a state
- in_state  input  128  state; column c = in_state[127-32c -: 32], row-0 byte at the MSB of each column
- in_bypass  input  1  final-round flag: pass state unmodified
- out_valid  output  1  out_state valid
- out_ready  input  1  downstream accepts out_state
- out_state  output  128  InvMixColumns(in_state), or in_state when bypassed; same byte order as in_state
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, col=0.
  - out_state=128'h0, out_valid=0, in_ready=1, busy=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE:
    - in_ready=1.
    - On in_valid: latch in_state into src reg and in_bypass into byp reg; col←0; go to RUN.
  - RUN:
    - Each cycle compute columns col..col+COLS_PER_CYCLE-1 of src into the matching slices of out_state; col += COLS_PER_CYCLE.
    - When the last column is written, go to DONE.
    - in_ready=0.
  - DONE:
    - out_valid=1; out_state held stable.
    - On out_ready: go to IDLE, out_valid←0.
    - No accept in the same cycle (in_ready=0 in DONE).
- Latency:
  - out_valid rises (4/COLS_PER_CYCLE)+1 clock edges after the accept edge (5 edges for COLS_PER_CYCLE=1).
  - Throughput is one state per (4/COLS_PER_CYCLE)+2 cycles with out_ready tied high.
- Column math:
  - Each output byte uses the matrix rows [0e 0b 0d 09], [09 0e 0b 0d], [0d 09 0e 0b], [0b 0d 09 0e].
  - Products are formed in GF(2^8) with reduction polynomial 0x11B via xtime chains; sums are XOR.
  - Purely combinational per column; no multipliers or LUT ROMs.
- Bypass: byp=1 copies src columns unchanged, with the same timing as a normal pass.
- Untransformed slices of out_state keep their previous values until overwritten during RUN.
- in_state and in_bypass are sampled only on the accept edge; later changes are ignored.
- out_ready asserted in IDLE or RUN is ignored.
- rst asserted mid-RUN or in DONE returns to reset values immediately; the partial result is discarded.
- col wraps only via the RUN→DONE transition and never exceeds 3.
- An illegal COLS_PER_CYCLE value is a static error: an elaboration-time check (a generate block instantiating a non-existent module) makes the build fail.

Optional Feature:
- Macro: INV_MIXCOL_TRACE_EN.
- Defined: on each DONE entry, a simulation $display prints the hierarchical name (%m), the src state, out_state in hex, and the bypass flag.
- Defined: a 32-bit blocks_done counter increments on each out_valid&&out_ready handshake and is exposed as an extra output port blocks_done (reset 0, wraps at 2^32).
- Not defined: no display, no counter, no extra port; functional behaviour identical.

Decomposition:
- Shared package aes_pkg holds:
  - AES_POLY=8'h1B;
  - typedefs state_t [127:0], col_t [31:0], byte_t [7:0];
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - functions xtime, gmul9, gmul11, gmul13, gmul14.
- Sub-module inv_mixcol_col: combinational 32-bit column in → 32-bit column out.
  - Instantiated COLS_PER_CYCLE times.
  - Reusable by a future fully-parallel variant.

Test Plan:
- Reset mid-RUN: accept a state, assert rst on the 2nd RUN cycle → out_valid=0, out_state=0, in_ready=1 at once; the next accepted state completes correctly.
- FIPS-197 column vectors (COLS_PER_CYCLE=1): in_state = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 → out_state = 128'hdb135345_f20a225c_01010101_c6c6c6c6, with out_valid exactly 5 edges after accept.
- Bypass: same input with in_bypass=1 → out_state equals in_state; same latency.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid stays 1, out_state stable, in_ready=0, and a new in_valid is ignored; out_ready=1 → IDLE next cycle.
- Parameter sweep COLS_PER_CYCLE=2 and 4: same vectors → identical out_state, with latency 3 and 2 edges respectively.

Source files
------------

// File: rtl/inv_mixcol_seq_pkg.sv
// Shared AES definitions: GF(2^8) helpers, common word types and the FSM encoding
// used by the column-serial InvMixColumns stage.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Higher multiples are built from the x2/x4/x8 chain and XORed together.
    function automatic byte_t gmul9(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic byte_t gmul11(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic byte_t gmul13(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic byte_t gmul14(input byte_t b);
        byte_t x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mixcol_seq_if.sv
// Handshake bundle for the InvMixColumns stage: upstream state in, result out.
interface inv_mixcol_seq_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   in_bypass;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;
    logic   busy;

    modport master (
        output in_valid, in_state, in_bypass, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, in_bypass, out_ready,
        output in_ready, out_valid, out_state, busy
    );

endinterface

// File: rtl/inv_mixcol_seq_col.sv
// One InvMixColumns column: purely combinational, row-0 byte at the MSB.
module inv_mixcol_col
    import aes_pkg::*;
(
    input  col_t col_i,
    output col_t col_o
);

    byte_t a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign col_o = {
        gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
        gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
        gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
        gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)
    };

endmodule

// File: rtl/inv_mixcol_seq.sv
// Column-serial AES InvMixColumns stage, COLS_PER_CYCLE columns per clock.
// Optional INV_MIXCOL_TRACE_EN adds a DONE-entry trace and a blocks_done counter port.
module inv_mixcol_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    inv_mixcol_seq_if.slave bus
`ifdef INV_MIXCOL_TRACE_EN
    ,
    output logic [31:0]     blocks_done
`endif
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            inv_mixcol_seq_illegal_cols_per_cycle u_bad ();
        end
    endgenerate

    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
    localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

    fsm_e       state_q;
    state_t     src_q;
    logic       byp_q;
    logic [1:0] col_q;
    logic [1:0] col_d;
    col_t       out_q [4];
    logic       in_ready_q;
    logic       out_valid_q;
    logic       busy_q;

    col_t src_cols [4];
    col_t res_cols [COLS_PER_CYCLE];

    assign col_d = col_q + COL_STEP;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_src
            assign src_cols[gi] = src_q[127 - 32*gi -: 32];
        end

        // One column engine per lane; lane gi works on column col_q+gi.
        for (gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            col_t sel_col;
            col_t mix_col;
            assign sel_col = src_cols[col_q + 2'(gi)];
            inv_mixcol_col u_col (
                .col_i (sel_col),
                .col_o (mix_col)
            );
            assign res_cols[gi] = byp_q ? sel_col : mix_col;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= '0;
            byp_q       <= 1'b0;
            col_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < 4; k++) out_q[k] <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        src_q      <= bus.in_state;
                        byp_q      <= bus.in_bypass;
                        col_q      <= 2'd0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++)
                        out_q[col_q + 2'(k)] <= res_cols[k];
                    if (col_q == LAST_COL) begin
                        col_q       <= 2'd0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        col_q <= col_d;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_state = {out_q[0], out_q[1], out_q[2], out_q[3]};

`ifdef INV_MIXCOL_TRACE_EN
    logic [31:0] blocks_done_q;
    logic        trace_done_q;

    // Trace fires in the first DONE cycle so out_state already holds the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocks_done_q <= 32'd0;
            trace_done_q  <= 1'b0;
        end else begin
            trace_done_q <= (state_q == DONE);
            if (state_q == DONE && !trace_done_q)
                $display("%m src=%h out=%h byp=%0d", src_q, bus.out_state, byp_q);
            if (out_valid_q && bus.out_ready)
                blocks_done_q <= blocks_done_q + 32'd1;
        end
    end

    assign blocks_done = blocks_done_q;
`endif

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Directed bench: three DUTs (1, 2, 4 columns per cycle) share one stimulus stream.
module tb_inv_mixcol_seq;

    typedef struct {
        logic [127:0] st;
        logic         byp;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_ready;

    logic [2:0]   ov;
    logic [2:0]   ir;
    logic [2:0]   bz;
    logic [127:0] os [3];

    int checks = 0;
    int errors = 0;
    int lat_exp [3];
    logic [127:0] prev_exp;
    vec_t vecs [6];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int C = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
            inv_mixcol_seq_if u_if ();
            assign u_if.in_valid  = in_valid;
            assign u_if.in_state  = in_state;
            assign u_if.in_bypass = in_bypass;
            assign u_if.out_ready = out_ready;
            assign ov[gi] = u_if.out_valid;
            assign ir[gi] = u_if.in_ready;
            assign bz[gi] = u_if.busy;
            assign os[gi] = u_if.out_state;
`ifdef INV_MIXCOL_TRACE_EN
            logic [31:0] bd;
`endif
            inv_mixcol_seq #(.COLS_PER_CYCLE(C)) u_dut (
                .clk (clk),
                .rst (rst),
                .bus (u_if.slave)
`ifdef INV_MIXCOL_TRACE_EN
                ,
                .blocks_done (bd)
`endif
            );
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h want %h", nm, inst, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_out_valid"}, i, 128'(ov[i]), 128'd0);
            chk({nm, "_in_ready"},  i, 128'(ir[i]), 128'd1);
            chk({nm, "_busy"},      i, 128'(bz[i]), 128'd0);
        end
    endtask

    // Edges are counted with the accept edge as edge 1; out_valid is checked
    // after each edge, so C=1 must first show it after edge 5.
    task automatic run_vec(input vec_t v, input int idx);
        int lat [3];
        in_valid  = 1'b1;
        in_state  = v.st;
        in_bypass = v.byp;
        out_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
        in_state  = ~v.st;
        in_bypass = ~v.byp;
        for (int i = 0; i < 3; i++) lat[i] = 0;
        for (int e = 2; e <= 12; e++) begin
            tick();
            if (e == 2) begin
                chk("first_col", 0, 128'(os[0][127:96]), 128'(v.exp[127:96]));
                chk("kept_cols", 0, 128'(os[0][95:0]),   128'(prev_exp[95:0]));
            end
            for (int i = 0; i < 3; i++)
                if (lat[i] == 0 && ov[i]) lat[i] = e;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            chk("latency",   i, 128'(lat[i]), 128'(lat_exp[i]));
            chk("out_state", i, os[i], v.exp);
            chk("done_in_ready", i, 128'(ir[i]), 128'd0);
            chk("done_busy", i, 128'(bz[i]), 128'd1);
        end
        $display("vec %0d in=%h byp=%0d out=%h lat=%0d/%0d/%0d", idx, v.st, v.byp, os[0], lat[0], lat[1], lat[2]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle("release");
        prev_exp = v.exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        lat_exp[0] = 5;
        lat_exp[1] = 3;
        lat_exp[2] = 2;
        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0, 128'hdb135345_f20a225c_01010101_c6c6c6c6};
        vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        vecs[2] = '{128'hd5d5d7d6_4d7ebdf8_8e4da1bc_01010101, 1'b0, 128'hd4d4d4d5_2d26314c_db135345_01010101};
        vecs[3] = '{128'h01000000_00010000_00000100_00000001, 1'b0, 128'h0e090d0b_0b0e090d_0d0b0e09_090d0b0e};
        vecs[4] = '{128'hff000000_ffffffff_00000000_000000ff, 1'b0, 128'h8d4697a3_ffffffff_00000000_4697a38d};
        vecs[5] = '{128'h01000000_00010000_00000100_00000001, 1'b1, 128'h01000000_00010000_00000100_00000001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        in_bypass = 1'b0;
        out_ready = 1'b0;
        prev_exp  = '0;
        tick();
        tick();
        chk_idle("reset");
        for (int i = 0; i < 3; i++) chk("reset_out_state", i, os[i], 128'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

        // Backpressure: result must hold while a competing in_valid is ignored.
        in_valid  = 1'b1;
        in_state  = vecs[2].st;
        in_bypass = 1'b0;
        tick();
        in_state  = vecs[3].st;
        for (int e = 0; e < 6; e++) tick();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 3; i++) begin
                chk("bp_out_valid", i, 128'(ov[i]), 128'd1);
                chk("bp_out_state", i, os[i], vecs[2].exp);
                chk("bp_in_ready",  i, 128'(ir[i]), 128'd0);
            end
            tick();
        end
        $display("backpressure out=%h", os[0]);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_idle("bp_release");
        tick();
        for (int i = 0; i < 3; i++) chk("bp_no_accept", i, 128'(bz[i]), 128'd0);
        prev_exp = vecs[2].exp;

        // Reset during the second RUN cycle discards the partial result.
        in_valid  = 1'b1;
        in_state  = vecs[4].st;
        in_bypass = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk_idle("midrun_rst");
        for (int i = 0; i < 3; i++) chk("midrun_rst_out_state", i, os[i], 128'd0);
        $display("midrun reset out=%h", os[0]);
        #1;
        rst = 1'b0;
        tick();
        prev_exp = '0;
        run_vec(vecs[0], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
